// File: rtl/bias_add_seq_if.sv
// Control, buffer-read, adder and result-write signals of the bias-add sequencer.
// master = sequencer side, slave = buffers/adder/controller side.
interface bias_add_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] vec_data;
    logic [DATA_WIDTH-1:0] bias_data;
    logic                  add_start;
    logic                  add_done;
    logic [DATA_WIDTH-1:0] add_value_in;
    logic [DATA_WIDTH-1:0] add_bias;
    logic [DATA_WIDTH-1:0] add_value_out;
    logic                  res_we;
    logic [ADDR_WIDTH-1:0] res_addr;
    logic [DATA_WIDTH-1:0] res_data;

    modport master (
        input  start, len, vec_data, bias_data, add_done, add_value_out,
        output busy, done, err, rd_addr, add_start, add_value_in, add_bias,
               res_we, res_addr, res_data
    );

    modport slave (
        output start, len, vec_data, bias_data, add_done, add_value_out,
        input  busy, done, err, rd_addr, add_start, add_value_in, add_bias,
               res_we, res_addr, res_data
    );
endinterface

// File: rtl/bias_add_seq.sv
// Sequencer driving the shared FP32 adder over a vector/bias buffer pair.
// Optional adder watchdog: define ADD_TIMEOUT_EN (limit = TIMEOUT cycles in WAIT_ADD).
module bias_add_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic           clk,
    input  logic           rst,
    bias_add_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, LAUNCH, WAIT_ADD, WRITE, FIN} state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W  = '0;

    state_t                state;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  last;
    logic                  tmo_hit;

    assign last = ({1'b0, index} == len_q - 1'b1);

`ifdef ADD_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Counter restarts on every entry to WAIT_ADD; a done in the last allowed cycle still wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_ADD) ? tmo_cnt + 1'b1 : '0;
            if (state == IDLE && bus.start)
                err_q <= 1'b0;
            else if (tmo_hit)
                err_q <= 1'b1;
        end
    end

    assign tmo_hit = (state == WAIT_ADD) && !bus.add_done && (tmo_cnt == TW'(TIMEOUT - 1));
    assign bus.err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            index            <= '0;
            len_q            <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.rd_addr      <= '0;
            bus.add_start    <= 1'b0;
            bus.add_value_in <= ZERO_W;
            bus.add_bias     <= ZERO_W;
            bus.res_we       <= 1'b0;
            bus.res_addr     <= '0;
            bus.res_data     <= ZERO_W;
        end else begin
            bus.done      <= 1'b0;
            bus.add_start <= 1'b0;
            bus.res_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        index       <= '0;
                        bus.rd_addr <= '0;
                        if (bus.len == '0) begin
                            bus.done <= 1'b1;
                            state    <= FIN;
                        end else begin
                            len_q    <= (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
                            bus.busy <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    bus.add_value_in <= bus.vec_data;
                    bus.add_bias     <= bus.bias_data;
                    bus.add_start    <= 1'b1;
                    state            <= LAUNCH;
                end
                // add_done is not looked at here: a level done from the previous add may still be high.
                LAUNCH: state <= WAIT_ADD;
                WAIT_ADD: begin
                    if (bus.add_done) begin
                        bus.res_data <= bus.add_value_out;
                        bus.res_addr <= index;
                        bus.res_we   <= 1'b1;
                        state        <= WRITE;
                    end else if (tmo_hit) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end
                end
                WRITE: begin
                    if (last) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        index       <= index + 1'b1;
                        bus.rd_addr <= index + 1'b1;
                        state       <= FETCH;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bias_add_seq.md
Name: bias_add_seq

Overview:
- Initiator-side sequencer for the FP32 adder's start/done handshake.
- Walks a vector buffer and a bias buffer element by element. For each element it launches one add through the adder, waits for the adder's done, then writes the sum to a result buffer.
- Sits between the GRU gate pre-activation buffers and the shared FP32 adder. It replaces hand-driven start/done sequencing.

Parameters:
DATA_WIDTH, 32, float word width (IEEE-754 single)
ADDR_WIDTH, 4, buffer address width; max vector length 2**ADDR_WIDTH
TIMEOUT, 64, watchdog cycle limit per add (used only with ADD_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to process a vector; sampled only in IDLE
len  in  ADDR_WIDTH+1  element count; latched on accepted start
busy  out  1  high from accepted start until the cycle done pulses
done  out  1  one-cycle pulse when the vector is finished (or aborted)
err  out  1  sticky adder-timeout flag; cleared on next accepted start
rd_addr  out  ADDR_WIDTH  shared read address to vector and bias buffers
vec_data  in  DATA_WIDTH  vector buffer data; valid 1 cycle after rd_addr
bias_data  in  DATA_WIDTH  bias buffer data; valid 1 cycle after rd_addr
add_start  out  1  one-cycle start pulse to adder
add_done  in  1  adder done (level or pulse)
add_value_in  out  DATA_WIDTH  operand A to adder
add_bias  out  DATA_WIDTH  operand B to adder
add_value_out  in  DATA_WIDTH  adder result; valid while add_done high
res_we  out  1  one-cycle result write enable
res_addr  out  ADDR_WIDTH  result write address
res_data  out  DATA_WIDTH  result write data

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; index=0; err=0. A reset mid-vector aborts with no res_we and no done.
- IDLE:
  - On start=1 with len!=0: latch len, index=0, err=0, busy=1, go to FETCH.
  - On start=1 with len=0: pulse done in the next cycle, with no writes and no busy.
- FETCH: drive rd_addr=index; go to CAPTURE.
- CAPTURE: register vec_data into add_value_in and bias_data into add_bias; go to LAUNCH.
- LAUNCH: add_start=1 for exactly this cycle; go to WAIT_ADD.
  - Operands are held stable from LAUNCH until the add_done cycle is consumed.
- WAIT_ADD:
  - add_done is ignored in the LAUNCH cycle. This guards against a level done left high from the previous add.
  - From the first WAIT_ADD cycle, add_done=1 captures add_value_out into res_data and moves to WRITE.
- WRITE: res_we=1 and res_addr=index for one cycle.
  - If index==len-1, go to FIN.
  - Otherwise index+1, go to FETCH.
- FIN: done=1 and busy=0 in the same cycle; go to IDLE.
- Per-element latency = 4 cycles + adder latency (cycles spent in WAIT_ADD).
- Vector latency from the accepted-start edge to done = len*(4+k)+1, where k is the adder latency.
- start while busy: ignored, no queuing.
- A start asserted in the FIN cycle is ignored; it is accepted on the following IDLE cycle.
- len > 2**ADDR_WIDTH: clamped to 2**ADDR_WIDTH.
- The block does no arithmetic on data. Words pass bit-exact; NaN/Inf/denormals are forwarded unchanged.

Optional Feature:
- ADD_TIMEOUT_EN defined:
  - A counter runs in WAIT_ADD. If add_done is not seen within TIMEOUT cycles, set err=1, skip the remaining elements with no res_we, and go to FIN (done pulses).
  - err stays high until the next accepted start.
- ADD_TIMEOUT_EN undefined: WAIT_ADD waits indefinitely; err is tied to 0.

Test Plan:
- Two-element vector, adder model latency 3, len=2:
  - vec={0x41200000, 0x40400000}, bias={0xC0800000, 0x40A00000}.
  - Required: res_we at addr0 with 0x40C00000, then at addr1 with 0x41000000.
  - Required: exactly 2 add_start pulses; done at cycle 2*(4+3)+1=15; busy low after.
- Adder whose done stays high until the next start:
  - Required: no element completes in its LAUNCH cycle.
  - Required: every res_data matches the current operands' sum.
- len=0:
  - Required: done in the next cycle; no add_start, res_we or busy.
- start pulsed again while busy with len=2 mid-vector:
  - Required: ignored; exactly 2 writes, 1 done.
- rst asserted in WAIT_ADD of element 1 of 4:
  - Required: all outputs 0 immediately; no further res_we; next start re-runs from addr0.
- ADD_TIMEOUT_EN, TIMEOUT=8, adder never asserts done, len=3:
  - Required: err=1 and done pulse 8 cycles into WAIT_ADD of element 0; zero res_we.
  - Required: err cleared on the next start.
